// File: rtl/led_pkg.sv
// Shared types and constants for the 4x4 LED matrix driver.
package led_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;
   localparam logic [3:0] DEFAULT_BRIGHTNESS = 4'b0010;

   typedef logic [3:0] pixel_t;
   typedef pixel_t [NUM_ROWS-1:0][NUM_COLS-1:0] frame_t;

   // Effective intensity: upper nibble of pixel * (brightness + 1), range 0..15.
   function automatic pixel_t scale_intensity(input pixel_t value, input pixel_t bright);
      logic [7:0] prod;
      prod = {4'b0000, value} * ({4'b0000, bright} + 8'd1);
      return prod[7:4];
   endfunction

endpackage

// File: rtl/led_matrix_driver_pwm_timebase.sv
// PWM timebase: prescaler, PWM slot counter and row counter for the row scan.
module pwm_timebase
   import led_pkg::*;
#(
   parameter int         PRESCALE = 4,
   parameter logic [3:0] PWM_LAST = 4'd15
) (
   input  logic       HCLK,
   input  logic       HRESETn,
   input  logic       enable,
   output logic       tick,
   output logic [3:0] pwm_cnt,
   output logic [1:0] row,
   output logic       frame_boundary
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
   localparam logic [1:0] ROW_LAST = 2'(NUM_ROWS - 1);

   logic [PS_W-1:0] presc_cnt;

   assign tick = enable && (presc_cnt == PS_MAX);
   // High while the counters sit in the last slot of the last row; the tick
   // that leaves this slot is the edge that wraps the frame.
   assign frame_boundary = (row == ROW_LAST) && (pwm_cnt == PWM_LAST);

   // Prescaler, PWM slot and row counters; all frozen while scanning is idle.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         presc_cnt <= '0;
         pwm_cnt   <= '0;
         row       <= '0;
      end else if (enable) begin
         if (tick) begin
            presc_cnt <= '0;
            if (pwm_cnt == PWM_LAST) begin
               pwm_cnt <= '0;
               row     <= row + 2'd1;
            end else begin
               pwm_cnt <= pwm_cnt + 4'd1;
            end
         end else begin
            presc_cnt <= presc_cnt + PS_W'(1);
         end
      end
   end

endmodule

// File: rtl/led_matrix_driver.sv
// 4x4 LED matrix driver: double-buffered frame, row scan with per-pixel PWM
// scaled by global brightness, and a per-frame pixel readback strobe.
// Optional build macro ROW_BLANK_EN blanks row and columns during PWM slot 0
// of every row as anti-ghosting dead time.
module led_matrix_driver
   import led_pkg::*;
#(
   parameter int PRESCALE  = 4,
   parameter int PWM_STEPS = 16
) (
   input  logic       HCLK,
   input  logic       HRESETn,
   input  frame_t     pixels,
   input  logic       load_enable,
   input  logic [3:0] brightness_value,
   output logic [3:0] row_sel,
   output logic [3:0] col_drive,
   output logic       output_enable,
   output logic [3:0] pixel
);

   localparam logic [3:0] PWM_LAST = 4'(PWM_STEPS - 1);

   frame_t     active;
   frame_t     shadow;
   pixel_t     active_bright;
   pixel_t     shadow_bright;
   logic       pending;
   logic       running;
   logic [3:0] ptr;

   logic       tick;
   logic [3:0] pwm_cnt;
   logic [1:0] row;
   logic       last_slot;
   logic       frame_end;
   logic       commit;
   logic [3:0] row_next;
   logic [3:0] col_next;

   pwm_timebase #(
      .PRESCALE (PRESCALE),
      .PWM_LAST (PWM_LAST)
   ) u_timebase (
      .HCLK           (HCLK),
      .HRESETn        (HRESETn),
      .enable         (running),
      .tick           (tick),
      .pwm_cnt        (pwm_cnt),
      .row            (row),
      .frame_boundary (last_slot)
   );

   assign frame_end = tick && last_slot;
   // A pending shadow goes live immediately when idle, otherwise at frame end.
   assign commit = pending && (!running || frame_end);

   // Shadow capture, shadow->active commit and the running flag.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         active        <= '0;
         shadow        <= '0;
         active_bright <= DEFAULT_BRIGHTNESS;
         shadow_bright <= DEFAULT_BRIGHTNESS;
         pending       <= 1'b0;
         running       <= 1'b0;
      end else if (load_enable && frame_end) begin
         // Load landing on the frame edge bypasses the shadow entirely.
         active        <= pixels;
         active_bright <= brightness_value;
         pending       <= 1'b0;
      end else begin
         if (commit) begin
            active        <= shadow;
            active_bright <= shadow_bright;
            pending       <= 1'b0;
            running       <= 1'b1;
         end
         if (load_enable) begin
            shadow        <= pixels;
            shadow_bright <= brightness_value;
            pending       <= 1'b1;
         end
      end
   end

   // Row select and PWM compare for the row currently being scanned.
   always_comb begin
      row_next = running ? (4'b0001 << row) : 4'b0000;
      col_next = 4'b0000;
      for (int c = 0; c < NUM_COLS; c++) begin
         col_next[c] = running && (pwm_cnt < scale_intensity(active[row][c], active_bright));
      end
`ifdef ROW_BLANK_EN
      if (pwm_cnt == 4'd0) begin
         row_next = 4'b0000;
         col_next = 4'b0000;
      end
`else
`endif
   end

   // Registered matrix drive plus frame-end readback of the pre-commit buffer.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         row_sel       <= 4'b0000;
         col_drive     <= 4'b0000;
         output_enable <= 1'b0;
         pixel         <= 4'b0000;
         ptr           <= 4'd0;
      end else begin
         row_sel       <= row_next;
         col_drive     <= col_next;
         output_enable <= frame_end;
         if (frame_end) begin
            pixel <= active[ptr[3:2]][ptr[1:0]];
            ptr   <= ptr + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_led_matrix_driver.sv
// Self-checking bench for led_matrix_driver: table-driven intensity vectors,
// hand-written multi-cycle sequences and randomized loads, all compared each
// cycle against a frame-position reference model.
module tb_led_matrix_driver;
   import led_pkg::*;

   localparam int P     = 4;
   localparam int FRAME = 64 * P;

   logic       HCLK = 1'b0;
   logic       HRESETn = 1'b0;
   frame_t     drv_pix;
   logic       drv_le;
   logic [3:0] drv_br;
   logic [3:0] row_sel;
   logic [3:0] col_drive;
   logic       output_enable;
   logic [3:0] pixel;

   led_matrix_driver #(.PRESCALE(P), .PWM_STEPS(16)) dut (
      .HCLK             (HCLK),
      .HRESETn          (HRESETn),
      .pixels           (drv_pix),
      .load_enable      (drv_le),
      .brightness_value (drv_br),
      .row_sel          (row_sel),
      .col_drive        (col_drive),
      .output_enable    (output_enable),
      .pixel            (pixel)
   );

   always #5 HCLK = ~HCLK;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: scan position is derived arithmetically from cycles
   // elapsed since scanning started.
   int         m_act [16];
   int         m_shd [16];
   int         m_ab, m_sb, m_t, m_ptr;
   bit         m_pend, m_run;
   logic [3:0] e_rs, e_cd, e_px;
   logic       e_oe;

   typedef struct {
      logic [3:0] pix;
      logic [3:0] br;
      int         on_per_col;
   } vec_t;
   vec_t tbl [8];

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_act[i] = 0;
         m_shd[i] = 0;
      end
      m_ab = 2; m_sb = 2; m_t = 0; m_ptr = 0;
      m_pend = 0; m_run = 0;
      e_rs = 0; e_cd = 0; e_px = 0; e_oe = 0;
   endtask

   task automatic model_edge();
      int row, pwm, eff;
      bit bnd, start;
      row = (m_t / (16 * P)) % 4;
      pwm = (m_t / P) % 16;
      bnd = m_run && (m_t == FRAME - 1);
      e_rs = m_run ? 4'(1 << row) : 4'd0;
      for (int c = 0; c < 4; c++) begin
         eff = (m_act[row * 4 + c] * (m_ab + 1)) / 16;
         e_cd[c] = m_run && (pwm < eff);
      end
`ifdef ROW_BLANK_EN
      if (pwm == 0) begin
         e_rs = 0;
         e_cd = 0;
      end
`endif
      e_oe = bnd;
      if (bnd) begin
         e_px  = 4'(m_act[m_ptr]);
         m_ptr = (m_ptr + 1) % 16;
      end
      start = 0;
      if (drv_le && bnd) begin
         for (int i = 0; i < 16; i++) m_act[i] = int'(drv_pix[i / 4][i % 4]);
         m_ab   = int'(drv_br);
         m_pend = 0;
      end else begin
         if (m_pend && (!m_run || bnd)) begin
            m_act  = m_shd;
            m_ab   = m_sb;
            m_pend = 0;
            start  = !m_run;
         end
         if (drv_le) begin
            for (int i = 0; i < 16; i++) m_shd[i] = int'(drv_pix[i / 4][i % 4]);
            m_sb   = int'(drv_br);
            m_pend = 1;
         end
      end
      if (start) begin
         m_run = 1;
         m_t   = 0;
      end else if (m_run) begin
         m_t = (m_t + 1) % FRAME;
      end
   endtask

   task automatic compare_outputs();
      n_vec++;
      if (row_sel !== e_rs || col_drive !== e_cd || output_enable !== e_oe || pixel !== e_px) begin
         n_bad++;
         $display("FAIL model_cycle t=%0t: row_sel=%h/%h col_drive=%h/%h oe=%b/%b pixel=%h/%h (actual/required)",
                  $time, row_sel, e_rs, col_drive, e_cd, output_enable, e_oe, pixel, e_px);
      end
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic step();
      @(posedge HCLK);
      if (!HRESETn) model_reset();
      else model_edge();
      @(negedge HCLK);
      compare_outputs();
      drv_le = 1'b0;
   endtask

   task automatic do_reset();
      HRESETn = 1'b0;
      step();
      step();
      check("reset_outputs", {row_sel, col_drive, output_enable, pixel}, 0);
      HRESETn = 1'b1;
   endtask

   task automatic set_uniform(input logic [3:0] v);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) drv_pix[r][c] = v;
   endtask

   task automatic load_uniform(input logic [3:0] v, input logic [3:0] b);
      set_uniform(v);
      drv_br = b;
      drv_le = 1'b1;
      step();
   endtask

   initial begin
      int on_bits, rs_cnt, nz, cnt, got;
      bit seen;
      drv_le = 1'b0;
      drv_br = 4'd0;
      set_uniform(4'd0);
      model_reset();
      tbl[0] = '{4'hF, 4'hF, 60};
      tbl[1] = '{4'h8, 4'h1, 4};
      tbl[2] = '{4'hF, 4'h0, 0};
      tbl[3] = '{4'h0, 4'hF, 0};
      tbl[4] = '{4'h1, 4'hF, 4};
      tbl[5] = '{4'h4, 4'h3, 4};
      tbl[6] = '{4'hF, 4'h7, 28};
      tbl[7] = '{4'hA, 4'h9, 24};
      @(negedge HCLK);

      // Reset, then idle with no load: row_sel must stay dark.
      do_reset();
      nz = 0;
      for (int k = 0; k < 300; k++) begin
         step();
         if (row_sel != 0) nz++;
      end
      check("idle_row_sel_dark", nz, 0);

      // Intensity table: one row dwell after a fresh load.
      for (int v = 0; v < 8; v++) begin
         int req_on, req_rs;
         do_reset();
         load_uniform(tbl[v].pix, tbl[v].br);
         step();
         on_bits = 0;
         rs_cnt  = 0;
         for (int k = 0; k < 64; k++) begin
            step();
            on_bits += $countones(col_drive);
            if (row_sel == 4'b0001) rs_cnt++;
         end
         req_on = 4 * tbl[v].on_per_col;
         req_rs = 64;
`ifdef ROW_BLANK_EN
         req_on = (tbl[v].on_per_col > 0) ? 4 * (tbl[v].on_per_col - 4) : 0;
         req_rs = 60;
`endif
         check($sformatf("row0_on_bits[%0d]", v), on_bits, req_on);
         check($sformatf("row0_sel_cycles[%0d]", v), rs_cnt, req_rs);
         step();
`ifdef ROW_BLANK_EN
         check($sformatf("row1_start[%0d]", v), row_sel, 0);
`else
         check($sformatf("row1_start[%0d]", v), row_sel, 4'b0010);
`endif
      end

      // Double buffer: mid-frame load waits for the frame edge.
      do_reset();
      load_uniform(4'hF, 4'hF);
      for (int k = 0; k < 100; k++) step();
      load_uniform(4'h0, 4'hF);
      nz = 0; seen = 0;
      for (int k = 0; k < 300 && !seen; k++) begin
         step();
         if (output_enable) seen = 1;
         else if (col_drive != 0) nz++;
      end
      check("dbuf_boundary_seen", seen, 1);
      check("dbuf_old_frame_kept", nz > 0, 1);
      nz = 0; cnt = 0; seen = 0;
      for (int k = 0; k < 600 && !seen; k++) begin
         step();
         cnt++;
         if (output_enable) seen = 1;
         if (col_drive != 0) nz++;
      end
      check("dbuf_new_frame_dark", nz, 0);
      check("oe_period", cnt, FRAME);

      // Readback: successive frame strobes walk the buffer 0..15 then wrap.
      do_reset();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) drv_pix[r][c] = 4'(4 * r + c);
      drv_br = 4'd5;
      drv_le = 1'b1;
      step();
      got = 0;
      for (int k = 0; k < 17 * FRAME + 300 && got < 17; k++) begin
         step();
         if (output_enable) begin
            check($sformatf("readback[%0d]", got), pixel, got % 16);
            got++;
         end
      end
      check("readback_count", got, 17);

      // Collision: load on the frame edge is live in the very next frame.
      do_reset();
      load_uniform(4'hF, 4'hF);
      seen = 0;
      for (int k = 0; k < 2 * FRAME && !seen; k++) begin
         if (m_run && m_t == FRAME - 1) seen = 1;
         else step();
      end
      check("collision_edge_found", seen, 1);
      load_uniform(4'h0, 4'hF);
      check("collision_oe", output_enable, 1);
      nz = 0;
      for (int k = 0; k < FRAME; k++) begin
         step();
         if (col_drive != 0) nz++;
      end
      check("collision_new_frame_dark", nz, 0);

      // Asynchronous reset mid-row clears outputs before the next edge.
      load_uniform(4'hF, 4'hF);
      for (int k = 0; k < 2 * FRAME + 70; k++) step();
      check("pre_reset_active", row_sel != 0, 1);
      #2;
      HRESETn = 1'b0;
      #1;
      check("async_reset_outputs", {row_sel, col_drive, output_enable, pixel}, 0);
      model_reset();
      step();
      HRESETn = 1'b1;
      step();

      // Randomized loads against the reference model.
      do_reset();
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 99) < 2) begin
            for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++) drv_pix[r][c] = 4'($urandom_range(0, 15));
            drv_br = 4'($urandom_range(0, 15));
            drv_le = 1'b1;
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
